// File: rtl/ram_reader_pkg.sv
// ram_reader_pkg: shared types, sizing helper and default widths for the RAM read engine.
//   clogb2  - number of bits needed to hold the value passed in (clogb2(511) = 9)
//   state_e - read engine state
//   ADDR_W / CNT_W - address and word-count widths for the default 512-entry RAM
package ram_reader_pkg;

  function automatic int unsigned clogb2(input int unsigned depth);
    int unsigned d;
    int unsigned r;
    d = depth;
    r = 0;
    while (d > 0) begin
      r = r + 1;
      d = d >> 1;
    end
    return r;
  endfunction

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } state_e;

  localparam int unsigned RAM_DEPTH_DFLT = 512;
  localparam int unsigned ADDR_W         = clogb2(RAM_DEPTH_DFLT - 1);
  localparam int unsigned CNT_W          = ADDR_W + 1;

endpackage

// File: rtl/ram_reader_if.sv
// ram_reader_if: bundles the command, RAM read-port and output-stream signals of ram_reader.
//   master modport - the reader itself (drives cmd_ready, RAM port, stream, busy)
//   slave modport  - the surroundings (command source, RAM, stream consumer)
// DataW must match the RAM width, AddrW the RAM address width.
interface ram_reader_if
  import ram_reader_pkg::*;
#(
  parameter int unsigned DataW = 16,
  parameter int unsigned AddrW = ADDR_W
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [AddrW-1:0] cmd_addr;
  logic [AddrW:0]   cmd_len;

  logic [AddrW-1:0] ram_addrb;
  logic             ram_enb;
  logic             ram_regceb;
  logic [DataW-1:0] ram_doutb;

  logic             m_valid;
  logic             m_ready;
  logic [DataW-1:0] m_data;
  logic             m_last;

  logic             busy;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, ram_doutb, m_ready,
    output cmd_ready, ram_addrb, ram_enb, ram_regceb, m_valid, m_data, m_last, busy
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, ram_doutb, m_ready,
    input  cmd_ready, ram_addrb, ram_enb, ram_regceb, m_valid, m_data, m_last, busy
  );

endinterface

// File: rtl/ram_reader_fifo.sv
// ram_reader_fifo: register-based first-word-fall-through FIFO.
//   clka  - clock
//   rstb  - asynchronous active-high reset, clears contents and pointers
//   push  - write wdata at the tail (must not happen when full)
//   wdata - entry to write
//   pop   - drop the head entry (ignored when empty)
//   rdata - head entry, valid whenever empty is low
//   empty - no entries held
//   count - number of entries held, 0..Depth
module ram_reader_fifo #(
  parameter int unsigned Width = 17,
  parameter int unsigned Depth = 4
) (
  input  logic                       clka,
  input  logic                       rstb,
  input  logic                       push,
  input  logic [Width-1:0]           wdata,
  input  logic                       pop,
  output logic [Width-1:0]           rdata,
  output logic                       empty,
  output logic [$clog2(Depth+1)-1:0] count
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             full;
  logic             do_pop;

  // Explicit wrap so non-power-of-2 depths work.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign empty  = (count_q == '0);
  assign full   = (count_q == CntW'(Depth));
  assign do_pop = pop && !empty;
  assign rdata  = mem_q[rd_ptr_q];
  assign count  = count_q;

  always_ff @(posedge clka or posedge rstb) begin
    if (rstb) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (push && !do_pop) begin
        count_q <= count_q + CntW'(1);
      end else if (!push && do_pop) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  // The reader's credit scheme keeps this from ever happening.
  a_no_overflow: assert property (@(posedge clka) disable iff (rstb) !(push && full));

endmodule

// File: rtl/ram_reader.sv
// ram_reader: read-side engine for a simple dual-port block RAM.
// Takes a (start address, length) command, issues one RAM read per word on addrb/enb, tracks
// the fixed RAM read latency and streams the returned words out with valid/ready and a last flag.
//   clka                    - clock shared with the RAM
//   rstb                    - asynchronous active-high reset
//   bus.cmd_valid/ready     - command handshake, ready only while idle
//   bus.cmd_addr/len        - start address and word count (0..RAM_DEPTH)
//   bus.ram_addrb/enb       - RAM read address / enable, one enable cycle per word
//   bus.ram_regceb          - RAM output register enable, high from the first clock after reset
//   bus.ram_doutb           - RAM read data, RD_LATENCY cycles after the enable
//   bus.m_valid/ready/data  - output stream
//   bus.m_last              - final word of the command
//   bus.busy                - engine is not idle
// RD_LATENCY must be 1 or 2; FIFO_DEPTH >= RD_LATENCY+2 sustains one word per cycle.
module ram_reader
  import ram_reader_pkg::*;
#(
  parameter int unsigned RAM_WIDTH  = 16,
  parameter int unsigned RAM_DEPTH  = 512,
  parameter int unsigned RD_LATENCY = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic          clka,
  input logic          rstb,
  ram_reader_if.master bus
);

  localparam int unsigned      AddrW   = clogb2(RAM_DEPTH - 1);
  localparam int unsigned      CntW    = AddrW + 1;
  localparam int unsigned      UsedW   = $clog2(FIFO_DEPTH + 1);
  localparam logic [UsedW-1:0] UsedMax = UsedW'(FIFO_DEPTH);
  localparam logic [AddrW-1:0] AddrMax = AddrW'(RAM_DEPTH - 1);

  state_e                state_q;
  logic [AddrW-1:0]      cur_addr_q;
  logic [CntW-1:0]       rem_q;
  logic                  enb_q;
  logic                  regceb_q;
  // Reads issued and not yet popped from the FIFO: in-flight plus FIFO occupancy.
  logic [UsedW-1:0]      used_q;
  logic [UsedW-1:0]      used_next;
  logic [RD_LATENCY-1:0] pipe_vld_q;
  logic [RD_LATENCY-1:0] pipe_last_q;

  logic                  accept;
  logic                  issue_last;
  logic                  push;
  logic                  pop;
  logic                  fifo_empty;
  logic [UsedW-1:0]      fifo_count;
  logic [RAM_WIDTH:0]    fifo_rdata;

  assign accept     = bus.cmd_valid && (state_q == StIdle);
  assign issue_last = enb_q && (rem_q == CntW'(1));
  assign push       = pipe_vld_q[RD_LATENCY-1];
  assign pop        = !fifo_empty && bus.m_ready;

  // Credit seen by the next cycle's issue decision; a pop now frees its slot only from then on.
  always_comb begin
    used_next = used_q;
    if (enb_q) begin
      used_next = used_next + UsedW'(1);
    end
    if (pop) begin
      used_next = used_next - UsedW'(1);
    end
  end

  // ram_enb is registered, so the issue decision for the next cycle is made here using the
  // occupancy that cycle will see.
  always_ff @(posedge clka or posedge rstb) begin
    if (rstb) begin
      state_q    <= StIdle;
      cur_addr_q <= '0;
      rem_q      <= '0;
      enb_q      <= 1'b0;
      regceb_q   <= 1'b0;
      used_q     <= '0;
    end else begin
      regceb_q <= 1'b1;
      used_q   <= used_next;
      unique case (state_q)
        StIdle: begin
          enb_q <= 1'b0;
          if (accept) begin
            cur_addr_q <= bus.cmd_addr;
            rem_q      <= bus.cmd_len;
            // A zero-length command is consumed without leaving idle.
            if (bus.cmd_len != '0) begin
              state_q <= StRun;
              enb_q   <= (used_next < UsedMax);
            end
          end
        end
        StRun: begin
          if (enb_q) begin
            cur_addr_q <= (cur_addr_q == AddrMax) ? '0 : cur_addr_q + AddrW'(1);
            rem_q      <= rem_q - CntW'(1);
          end
          if (issue_last) begin
            state_q <= StDrain;
            enb_q   <= 1'b0;
          end else begin
            enb_q <= (used_next < UsedMax);
          end
        end
        StDrain: begin
          enb_q <= 1'b0;
          if ((pipe_vld_q == '0) && (fifo_count == '0)) begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
          enb_q   <= 1'b0;
        end
      endcase
    end
  end

  // Latency pipe: stage RD_LATENCY-1 lines up with the matching word on ram_doutb.
  always_ff @(posedge clka or posedge rstb) begin
    if (rstb) begin
      pipe_vld_q  <= '0;
      pipe_last_q <= '0;
    end else begin
      pipe_vld_q[0]  <= enb_q;
      pipe_last_q[0] <= issue_last;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_last_q[i] <= pipe_last_q[i-1];
      end
    end
  end

  ram_reader_fifo #(
    .Width (RAM_WIDTH + 1),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clka  (clka),
    .rstb  (rstb),
    .push  (push),
    .wdata ({pipe_last_q[RD_LATENCY-1], bus.ram_doutb}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.cmd_ready  = (state_q == StIdle);
  assign bus.busy       = (state_q != StIdle);
  assign bus.ram_addrb  = cur_addr_q;
  assign bus.ram_enb    = enb_q;
  assign bus.ram_regceb = regceb_q;
  assign bus.m_valid    = !fifo_empty;
  assign bus.m_data     = fifo_rdata[RAM_WIDTH-1:0];
  assign bus.m_last     = fifo_rdata[RAM_WIDTH];

endmodule

// File: tb/tb_ram_reader.sv
// Bench for ram_reader: a 2-cycle-latency RAM model preloaded with 16'hA000+i, a table of
// command vectors checked in a loop, and hand-written reset, zero-length and sweep sequences.
module tb_ram_reader;

  localparam int EXP_LAT = 4;  // accept cycle to first m_valid with RD_LATENCY = 2

  typedef struct {
    int          addr;
    int          len;
    bit          toggle;
    logic [15:0] exp_first;
    logic [15:0] exp_final;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    logic        last;
    int          cyc;
  } beat_t;

  logic clka = 1'b0;
  logic rstb;

  ram_reader_if #(.DataW(16), .AddrW(9)) bus ();

  ram_reader #(
    .RAM_WIDTH  (16),
    .RAM_DEPTH  (512),
    .RD_LATENCY (2),
    .FIFO_DEPTH (4)
  ) dut (
    .clka (clka),
    .rstb (rstb),
    .bus  (bus)
  );

  always #5 clka = ~clka;

  int cyc = 0;
  always @(posedge clka) cyc <= cyc + 1;

  // RAM model: array register then output register (HIGH_PERFORMANCE, latency 2).
  logic [15:0] ram [512];
  logic [15:0] ram_q;
  initial for (int i = 0; i < 512; i++) ram[i] = 16'(32'hA000 + i);
  always @(posedge clka) begin
    if (bus.ram_enb) ram_q <= ram[bus.ram_addrb];
    if (bus.ram_regceb) bus.ram_doutb <= ram_q;
  end

  // Stream consumer ready: held at 1, or the 1,0,0,1 pattern when toggle_mode is set.
  bit       toggle_mode = 1'b0;
  logic [3:0] pat = 4'b1001;
  int       ph = 0;
  initial begin
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clka);
      #1;
      bus.m_ready = toggle_mode ? pat[ph] : 1'b1;
      ph = (ph + 1) % 4;
    end
  end

  // Monitor, sampling at the falling edge.
  beat_t b;
  beat_t beat_q [$];
  int    addr_q [$];
  int    rise_q [$];
  int    issued = 0, popped = 0, max_out = 0, hold_err = 0;
  bit    prev_valid = 1'b0, hold_pend = 1'b0;
  logic [15:0] hold_data;
  logic        hold_last;

  always @(negedge clka) begin
    if (rstb) begin
      issued     = 0;
      popped     = 0;
      prev_valid = 1'b0;
      hold_pend  = 1'b0;
    end else begin
      if (bus.ram_enb) begin
        issued++;
        addr_q.push_back(int'(bus.ram_addrb));
      end
      if (bus.m_valid && !prev_valid) rise_q.push_back(cyc);
      prev_valid = bus.m_valid;
      if (hold_pend && (!bus.m_valid || bus.m_data !== hold_data || bus.m_last !== hold_last))
        hold_err++;
      hold_pend = bus.m_valid && !bus.m_ready;
      hold_data = bus.m_data;
      hold_last = bus.m_last;
      if (bus.m_valid && bus.m_ready) begin
        b.data = bus.m_data;
        b.last = bus.m_last;
        b.cyc  = cyc;
        beat_q.push_back(b);
        popped++;
      end
      if (issued - popped > max_out) max_out = issued - popped;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  function automatic int exp_word(input int a);
    return 32'hA000 + (a % 512);
  endfunction

  task automatic send_cmd(input int addr, input int len, output int acc);
    @(posedge clka);
    #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 9'(addr);
    bus.cmd_len   = 10'(len);
    acc = -1;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clka);
      if (bus.cmd_ready) begin
        acc = cyc;
        break;
      end
    end
    @(posedge clka);
    #1;
    bus.cmd_valid = 1'b0;
    if (acc < 0) begin
      checks++;
      failures++;
      $display("FAIL cmd_accept_timeout: got no accept expected accept addr=%0d len=%0d",
               addr, len);
    end
  endtask

  task automatic wait_beats(input string name, input int target);
    for (int n = 0; n < 3000 && beat_q.size() < target; n++) @(posedge clka);
    chk(name, beat_q.size(), target);
  endtask

  task automatic wait_idle(input string name);
    for (int n = 0; n < 2000; n++) begin
      @(negedge clka);
      if (bus.cmd_ready) break;
    end
    chk(name, int'(bus.cmd_ready), 1);
  endtask

  vec_t vec [5];
  int   bb, ab, rb, acc, acc2, nerr, lerr, aerr, lat, spur;

  initial begin
    vec[0] = '{5,   4, 1'b0, 16'hA005, 16'hA008};
    vec[1] = '{5,   4, 1'b1, 16'hA005, 16'hA008};
    vec[2] = '{510, 4, 1'b0, 16'hA1FE, 16'hA001};
    vec[3] = '{300, 7, 1'b1, 16'hA12C, 16'hA132};
    vec[4] = '{511, 1, 1'b0, 16'hA1FF, 16'hA1FF};

    rstb          = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    repeat (3) @(posedge clka);
    @(negedge clka);
    chk("rst_cmd_ready", int'(bus.cmd_ready), 1);
    chk("rst_ram_enb", int'(bus.ram_enb), 0);
    chk("rst_ram_regceb", int'(bus.ram_regceb), 0);
    chk("rst_ram_addrb", int'(bus.ram_addrb), 0);
    chk("rst_m_valid", int'(bus.m_valid), 0);
    chk("rst_m_last", int'(bus.m_last), 0);
    chk("rst_m_data", int'(bus.m_data), 0);
    chk("rst_busy", int'(bus.busy), 0);
    rstb = 1'b0;
    @(negedge clka);
    chk("regceb_after_reset", int'(bus.ram_regceb), 1);

    // Table-driven commands.
    for (int v = 0; v < 5; v++) begin
      bb = beat_q.size();
      ab = addr_q.size();
      rb = rise_q.size();
      toggle_mode = vec[v].toggle;
      send_cmd(vec[v].addr, vec[v].len, acc);
      chk($sformatf("v%0d_busy", v), int'(bus.busy), 1);
      wait_beats($sformatf("v%0d_beats", v), bb + vec[v].len);
      wait_idle($sformatf("v%0d_idle", v));
      toggle_mode = 1'b0;
      lat = (rise_q.size() > rb) ? rise_q[rb] - acc : -1;
      chk($sformatf("v%0d_latency", v), lat, EXP_LAT);
      chk($sformatf("v%0d_first", v), int'(beat_q[bb].data), int'(vec[v].exp_first));
      chk($sformatf("v%0d_final", v), int'(beat_q[bb + vec[v].len - 1].data),
          int'(vec[v].exp_final));
      nerr = 0;
      lerr = 0;
      aerr = 0;
      for (int k = 0; k < vec[v].len; k++) begin
        if (int'(beat_q[bb + k].data) != exp_word(vec[v].addr + k)) nerr++;
        if (beat_q[bb + k].last != (k == vec[v].len - 1)) lerr++;
        if (addr_q[ab + k] != (vec[v].addr + k) % 512) aerr++;
      end
      chk($sformatf("v%0d_order_errs", v), nerr, 0);
      chk($sformatf("v%0d_last_errs", v), lerr, 0);
      chk($sformatf("v%0d_addr_errs", v), aerr, 0);
      chk($sformatf("v%0d_issues", v), addr_q.size() - ab, vec[v].len);
      chk($sformatf("v%0d_busy_end", v), int'(bus.busy), 0);
      if (!vec[v].toggle)
        chk($sformatf("v%0d_span", v), beat_q[bb + vec[v].len - 1].cyc - beat_q[bb].cyc,
            vec[v].len - 1);
    end
    chk("outstanding_le_4", int'(max_out <= 4), 1);
    chk("hold_stable_errs", hold_err, 0);

    // Zero-length command: consumed, no beat, never busy.
    bb = beat_q.size();
    ab = addr_q.size();
    send_cmd(0, 0, acc);
    @(negedge clka);
    chk("len0_cmd_ready_next", int'(bus.cmd_ready), 1);
    spur = 0;
    repeat (8) begin
      @(negedge clka);
      if (bus.busy || bus.m_valid || bus.ram_enb) spur++;
    end
    chk("len0_quiet", spur, 0);
    chk("len0_no_beats", beat_q.size() - bb, 0);
    chk("len0_no_issues", addr_q.size() - ab, 0);

    // Asynchronous reset in the middle of a 16-word read.
    bb = beat_q.size();
    send_cmd(0, 16, acc);
    wait_beats("rst_mid_prebeats", bb + 5);
    #3;
    rstb = 1'b1;
    #1;
    chk("rst_mid_m_valid", int'(bus.m_valid), 0);
    chk("rst_mid_ram_enb", int'(bus.ram_enb), 0);
    chk("rst_mid_busy", int'(bus.busy), 0);
    repeat (2) @(posedge clka);
    @(negedge clka);
    rstb = 1'b0;
    spur = 0;
    repeat (8) begin
      @(negedge clka);
      if (bus.m_valid || bus.ram_enb || bus.busy) spur++;
    end
    chk("rst_release_quiet", spur, 0);
    bb = beat_q.size();
    send_cmd(0, 2, acc);
    wait_beats("rst_new_beats", bb + 2);
    wait_idle("rst_new_idle");
    repeat (6) @(posedge clka);
    chk("rst_new_exact_count", beat_q.size() - bb, 2);
    chk("rst_new_w0", int'(beat_q[bb].data), 32'hA000);
    chk("rst_new_w1", int'(beat_q[bb + 1].data), 32'hA001);
    chk("rst_new_last", int'({beat_q[bb].last, beat_q[bb + 1].last}), 1);

    // Full sweep followed by a back-to-back command.
    bb = beat_q.size();
    ab = addr_q.size();
    send_cmd(0, 512, acc);
    send_cmd(7, 3, acc2);
    wait_beats("sweep_beats", bb + 515);
    wait_idle("sweep_idle");
    nerr = 0;
    lerr = 0;
    for (int k = 0; k < 512; k++) begin
      if (int'(beat_q[bb + k].data) != exp_word(k)) nerr++;
      if (beat_q[bb + k].last != (k == 511)) lerr++;
    end
    chk("sweep_order_errs", nerr, 0);
    chk("sweep_last_errs", lerr, 0);
    chk("sweep_span", beat_q[bb + 511].cyc - beat_q[bb].cyc, 511);
    // Last pop in cycle L empties the FIFO; DRAIN sees it in L+1, IDLE and accept in L+2.
    chk("second_accept_cycle", acc2, beat_q[bb + 511].cyc + 2);
    chk("second_w0", int'(beat_q[bb + 512].data), 32'hA007);
    chk("second_w2", int'(beat_q[bb + 514].data), 32'hA009);
    chk("second_last", int'(beat_q[bb + 514].last), 1);
    chk("sweep_issues", addr_q.size() - ab, 515);
    chk("outstanding_le_4_end", int'(max_out <= 4), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
